// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// One operation at a time, fixed 34-cycle start-to-done latency for every
// funct3 (32 CALC iterations, one FINISH cycle, one DONE cycle).
// Multiply is radix-2 shift-add on operand magnitudes; divide is restoring
// shift-subtract. The sign is applied once in FINISH.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          request, accepted only in IDLE or DONE
//   flush          abort; forces IDLE, suppresses done, leaves result alone
//   funct3         000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                  100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a, op_b     rs1 / rs2 values
//   rd_in          destination register index
//   busy           high in CALC and FINISH
//   done           one-cycle pulse, result/rd_out valid
//   result         registered result
//   rd_out         destination index of the last completed op
//   wb_we          done with a non-x0 destination
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wb_we
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  // Operation context captured at start.
  typedef struct packed {
    logic [2:0]      f3;
    logic [4:0]      rd;
    logic [XLEN-1:0] opnd;    // multiplicand (mul) or divisor (div) magnitude
    logic [XLEN-1:0] orig_a;  // raw op_a, returned by REM/REMU on divide-by-zero
    logic            neg;     // negate the raw result in FINISH
    logic            div0;
    logic            ovf;
  } ctx_t;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  ctx_t              ctx_q, ctx_d, ctx_new;
  // Multiply: {partial product hi, multiplier/product lo}.
  // Divide:   {partial remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  // ---------------- start capture ----------------
  logic            a_signed, b_signed, a_neg, b_neg, new_is_div;
  logic [XLEN-1:0] a_mag, b_mag;

  always_comb begin
    a_signed   = (funct3 == F_MUL) || (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                 (funct3 == F_DIV) || (funct3 == F_REM);
    b_signed   = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
    a_neg      = a_signed & op_a[XLEN-1];
    b_neg      = b_signed & op_b[XLEN-1];
    a_mag      = a_neg ? -op_a : op_a;
    b_mag      = b_neg ? -op_b : op_b;
    new_is_div = funct3[2];

    ctx_new.f3     = funct3;
    ctx_new.rd     = rd_in;
    ctx_new.opnd   = new_is_div ? b_mag : a_mag;
    ctx_new.orig_a = op_a;
    // Remainder takes the dividend sign; everything else the XOR. For the
    // unsigned ops both a_neg and b_neg are already 0.
    ctx_new.neg    = (funct3 == F_REM) ? a_neg : (a_neg ^ b_neg);
    ctx_new.div0   = (op_b == '0);
    ctx_new.ovf    = ((funct3 == F_DIV) || (funct3 == F_REM)) &&
                     (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  end

  // ---------------- iteration step ----------------
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_hi, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] mul_nxt, div_nxt;

  always_comb begin
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, ctx_q.opnd} : {(XLEN+1){1'b0}});
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring divide: shift left one, trial-subtract the divisor from the
    // 33-bit partial remainder, keep the difference if it did not borrow.
    div_hi   = acc_q[2*XLEN-1:XLEN-1];
    div_diff = div_hi - {1'b0, ctx_q.opnd};
    div_ge   = ~div_diff[XLEN];
    div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : div_hi[XLEN-1:0]),
                acc_q[XLEN-2:0], div_ge};
  end

  // ---------------- finish: sign + overrides ----------------
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_raw, div_s, fin_res;
  logic              fin_quo;

  always_comb begin
    prod_s  = ctx_q.neg ? -acc_q : acc_q;
    fin_quo = (ctx_q.f3 == F_DIV) || (ctx_q.f3 == F_DIVU);
    div_raw = fin_quo ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
    div_s   = ctx_q.neg ? -div_raw : div_raw;

    if (!ctx_q.f3[2]) begin
      fin_res = (ctx_q.f3 == F_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end else if (ctx_q.div0) begin
      fin_res = fin_quo ? {XLEN{1'b1}} : ctx_q.orig_a;
    end else if (ctx_q.ovf) begin
      fin_res = fin_quo ? {1'b1, {(XLEN-1){1'b0}}} : {XLEN{1'b0}};
    end else begin
      fin_res = div_s;
    end
  end

  // ---------------- FSM / datapath next state ----------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctx_d    = ctx_q;
    acc_d    = acc_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_CALC;
          ctx_d   = ctx_new;
          cnt_d   = '0;
          acc_d   = {{XLEN{1'b0}}, (new_is_div ? a_mag : b_mag)};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = ctx_q.f3[2] ? div_nxt : mul_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = S_FIN;
        end
      end
      S_FIN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fin_res;
          rd_out_d = ctx_q.rd;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ctx_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ctx_q    <= ctx_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;
  assign wb_we  = done && (rd_out_q != 5'd0);

endmodule
